// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel emits a one-cycle pulse every D enabled cycles plus a divided level output.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 50,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_ack,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  div    [NUM_CH];
    logic [CNT_W-1:0]  sh_div [NUM_CH];
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] sh_mode;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;

    // Out-of-range channel numbers never match, so such writes are dropped silently.
    always_comb begin
        wr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_we && (32'(cfg_ch) == i);
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                div[i]    <= DEF_DIV;
                sh_div[i] <= DEF_DIV;
            end
            mode    <= '0;
            sh_mode <= '0;
            pend    <= '0;
            pulse   <= '0;
            clk_out <= '0;
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= |wr;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr[i]) begin
                    sh_div[i]  <= cfg_div;
                    sh_mode[i] <= cfg_mode;
                end
                if (sync) begin
                    // A write in the sync cycle bypasses the shadow so it is active immediately.
                    cnt[i]     <= '0;
                    pulse[i]   <= 1'b0;
                    clk_out[i] <= 1'b0;
                    pend[i]    <= 1'b0;
                    if (wr[i]) begin
                        div[i]  <= cfg_div;
                        mode[i] <= cfg_mode;
                    end else if (pend[i]) begin
                        div[i]  <= sh_div[i];
                        mode[i] <= sh_mode[i];
                    end
                end else if (!en[i] || div[i] == '0) begin
                    // Idle or stalled channel: configuration takes effect at once.
                    pulse[i] <= 1'b0;
                    if (mode[i]) clk_out[i] <= 1'b0;
                    if (div[i] == '0) cnt[i] <= '0;
                    if (wr[i]) begin
                        div[i]  <= cfg_div;
                        mode[i] <= cfg_mode;
                        cnt[i]  <= '0;
                        pend[i] <= 1'b0;
                    end
                end else if (cnt[i] == div[i] - ONE) begin
                    cnt[i]     <= '0;
                    pulse[i]   <= 1'b1;
                    clk_out[i] <= mode[i] ? 1'b1 : ~clk_out[i];
                    if (pend[i]) begin
                        div[i]  <= sh_div[i];
                        mode[i] <= sh_mode[i];
                    end
                    // A write on the wrap edge waits for the following wrap.
                    pend[i] <= wr[i];
                end else begin
                    cnt[i]   <= cnt[i] + ONE;
                    pulse[i] <= 1'b0;
                    if (mode[i]) clk_out[i] <= 1'b0;
                    if (wr[i]) pend[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised multi-channel clock divider and tick generator running from the 50 MHz system clock.
- Each of NUM_CH channels has its own runtime-programmable divisor and output mode.
- Each channel produces a one-cycle enable strobe (pulse) and a divided level output (clk_out).
- Successor to the single-channel fixed divider. Feeds timestamp counters, sampling enables and slow-bus timing in the acceleration pipeline.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 16, divisor/counter width in bits
DEFAULT_DIV, 50, divisor loaded into every channel at reset (1 MHz tick from 50 MHz)
CH_W, $clog2(NUM_CH) (min 1), width of channel select

Ports:
clk50  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel run enable
sync  in  1  single-cycle strobe; phase-aligns all channels
cfg_we  in  1  configuration write strobe
cfg_ch  in  CH_W  channel addressed by cfg_we
cfg_div  in  CNT_W  new divisor D
cfg_mode  in  1  new mode: 0 = toggle (square wave), 1 = strobe mirror
cfg_ack  out  1  one-cycle acknowledge of an accepted write
pulse  out  NUM_CH  one-cycle tick per channel, every D enabled cycles
clk_out  out  NUM_CH  divided level output per channel

Behaviour:
Reset (synchronous, rst sampled high):
- Per channel: cnt=0, active div=DEFAULT_DIV, shadow div=DEFAULT_DIV, mode=0, pend=0.
- pulse=0, clk_out=0, cfg_ack=0.
- rst has priority over every other input.

Per-channel counter, each clk50 edge with en[i]=1 and active D>=1:
- if cnt==D-1: cnt<=0, pulse[i]<=1; else cnt<=cnt+1, pulse[i]<=0.
- All outputs registered.
- en rising at edge k: first pulse high in the cycle after edge k+D-1; thereafter period exactly D cycles.
- D=1: pulse held high continuously while enabled.
- D=0: channel stalled, cnt held at 0, pulse=0, clk_out held.
- en[i]=0: cnt and clk_out hold; pulse[i]=0 next cycle. Re-enable resumes from the held cnt with no restart.

Modes:
- mode 0: clk_out[i] toggles on the same edge that sets pulse[i]. Period 2D, 50% duty.
- mode 1: clk_out[i] equals pulse[i] (identical register value).
- Switching mode does not clear clk_out.

Configuration:
- cfg_we with cfg_ch<NUM_CH: write cfg_div/cfg_mode into the channel shadow, set pend, cfg_ack=1 next cycle.
- cfg_ch>=NUM_CH: write ignored, no ack.
- Back-to-back writes accepted every cycle. A later write to the same channel overwrites the shadow before it applies; ack is given for each write.
- Shadow to active copy: on the edge where the channel wraps (cnt==D-1 while enabled), the new D applies from the next count. pend clears.
- Immediate copy (same edge as the write) if en[i]=0, or if active D=0. cnt<=0 in this case.
- No runt or partial period is ever produced by reconfiguration.

sync:
- All channels: cnt<=0, pulse<=0, clk_out<=0, regardless of en.
- Pending shadows are copied to active on the same edge.
- Same-cycle cfg_we: write lands in the shadow. With sync pending copy, the write is visible as active on that edge.
- Priority: rst > sync > wrap > cfg write.

Reset mid-operation: any count, pending write or clk_out state is discarded the cycle rst is sampled.

Test Plan:
- Reset then en=4'b0001, default D=50 -> pulse[0] high one cycle every 50 cycles; first pulse 50 edges after en; clk_out[0] period 100 cycles. Other channels silent with outputs 0.
- Write ch1 D=3 mode 0 while disabled, then en[1]=1 -> cfg_ack once; pulse[1] pattern 0,0,1 repeating; clk_out[1] toggles every 3 cycles (period 6).
- Ch0 running D=50 at cnt=20, write D=4 -> remaining 29 cycles complete at D=50, then pulses every 4 cycles; no pulse gap <4 or >50.
- Ch2 D=1 mode 1 -> pulse[2] and clk_out[2] constantly high while enabled. Write D=0 -> both go low, counter stalled.
- All channels running different D; assert sync -> next cycle every pulse/clk_out=0. With D=5 on all, pulses coincide 5 cycles after sync.
- cfg_we with cfg_ch=7 (NUM_CH=4 CH_W=2 edge case: use NUM_CH=5, cfg_ch=6) -> no ack, no change. rst asserted mid-period -> all outputs 0 next cycle, divisors back to 50.
